// File: rtl/peripheral_dsa_point_generator_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_dsa_point_generator_arbiter
// Purpose  : Shares one point generator among REQUESTERS clients. A
//            round-robin arbiter picks a client, latches its operands,
//            pulses GEN_START and waits for the generator to finish. A
//            watchdog bounds the wait. The result goes back to the winning
//            client together with a one-cycle READY or ERROR strobe.
// Ports    : CLK / RST                     clock, async active-low reset
//            REQ_VALID, REQ_POINT_IN_X/Y   per-client request level + operands
//            REQ_READY / REQ_ERROR         one-hot completion / timeout strobe
//            REQ_POINT_OUT_X/Y             broadcast result, valid with READY
//            GRANT_ID, BUSY                current winner, arbiter activity
//            GEN_START, GEN_POINT_IN_X/Y   launch pulse + operands to generator
//            GEN_READY, GEN_POINT_OUT_X/Y  generator status + result
// Revision : 1.0  initial release
// ============================================================================
module peripheral_dsa_point_generator_arbiter #(
    parameter int DATA_SIZE      = 64,
    parameter int REQUESTERS     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [REQUESTERS-1:0]             REQ_VALID,
    input  logic [REQUESTERS*DATA_SIZE-1:0]   REQ_POINT_IN_X,
    input  logic [REQUESTERS*DATA_SIZE-1:0]   REQ_POINT_IN_Y,
    output logic [REQUESTERS-1:0]             REQ_READY,
    output logic [REQUESTERS-1:0]             REQ_ERROR,
    output logic [DATA_SIZE-1:0]              REQ_POINT_OUT_X,
    output logic [DATA_SIZE-1:0]              REQ_POINT_OUT_Y,
    output logic [$clog2(REQUESTERS)-1:0]     GRANT_ID,
    output logic                              BUSY,
    output logic                              GEN_START,
    output logic [DATA_SIZE-1:0]              GEN_POINT_IN_X,
    output logic [DATA_SIZE-1:0]              GEN_POINT_IN_Y,
    input  logic                              GEN_READY,
    input  logic [DATA_SIZE-1:0]              GEN_POINT_OUT_X,
    input  logic [DATA_SIZE-1:0]              GEN_POINT_OUT_Y
);

    localparam int ID_W  = $clog2(REQUESTERS);
    // A disabled watchdog still needs a legal one-bit timer vector.
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [ID_W-1:0]  LAST_GRANT_RESET = ID_W'(REQUESTERS - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT        = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q,      state_d;
    logic [ID_W-1:0]         last_grant_q, last_grant_d;
    logic [ID_W-1:0]         grant_id_q,   grant_id_d;
    logic [DATA_SIZE-1:0]    gen_x_q,      gen_x_d;
    logic [DATA_SIZE-1:0]    gen_y_q,      gen_y_d;
    logic [DATA_SIZE-1:0]    out_x_q,      out_x_d;
    logic [DATA_SIZE-1:0]    out_y_q,      out_y_d;
    logic [TMR_W-1:0]        timer_q,      timer_d;
    logic                    seen_low_q,   seen_low_d;
    logic                    gen_start_q,  gen_start_d;
    logic                    busy_q,       busy_d;
    logic [REQUESTERS-1:0]   req_ready_q,  req_ready_d;
    logic [REQUESTERS-1:0]   req_error_q,  req_error_d;

    logic                    win_found;
    logic [ID_W-1:0]         win_idx;
    logic [REQUESTERS-1:0]   grant_onehot;

    assign grant_onehot = {{(REQUESTERS-1){1'b0}}, 1'b1} << grant_id_q;

    // Round-robin search: start just after the previous winner and wrap, so
    // the client served last is considered last.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int off = 1; off <= REQUESTERS; off++) begin
            cand = (int'(last_grant_q) + off) % REQUESTERS;
            if (!win_found && REQ_VALID[cand]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        gen_x_d      = gen_x_q;
        gen_y_d      = gen_y_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        timer_d      = timer_q;
        seen_low_d   = seen_low_q;
        gen_start_d  = 1'b0;
        req_ready_d  = '0;
        req_error_d  = '0;

        case (state_q)
            S_IDLE: begin
                // A generator still busy from a timed-out operation holds
                // GEN_READY low; no new grant until it recovers.
                if (win_found && GEN_READY) begin
                    grant_id_d  = win_idx;
                    gen_x_d     = REQ_POINT_IN_X[int'(win_idx)*DATA_SIZE +: DATA_SIZE];
                    gen_y_d     = REQ_POINT_IN_Y[int'(win_idx)*DATA_SIZE +: DATA_SIZE];
                    gen_start_d = 1'b1;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_d    = '0;
                seen_low_d = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // Completion only counts once GEN_READY has been seen low,
                // otherwise the idle level left over from before START
                // would be mistaken for a result.
                seen_low_d = seen_low_q | ~GEN_READY;
                if (GEN_READY && seen_low_q) begin
                    out_x_d     = GEN_POINT_OUT_X;
                    out_y_d     = GEN_POINT_OUT_Y;
                    req_ready_d = grant_onehot;
                    state_d     = S_DONE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    timer_d = timer_q + TMR_W'(1);
                    if (timer_d == TMR_LIMIT) begin
                        out_x_d     = '0;
                        out_y_d     = '0;
                        req_error_d = grant_onehot;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                last_grant_d = grant_id_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_GRANT_RESET;
            grant_id_q   <= '0;
            gen_x_q      <= '0;
            gen_y_q      <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            timer_q      <= '0;
            seen_low_q   <= 1'b0;
            gen_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            req_ready_q  <= '0;
            req_error_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            gen_x_q      <= gen_x_d;
            gen_y_q      <= gen_y_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            timer_q      <= timer_d;
            seen_low_q   <= seen_low_d;
            gen_start_q  <= gen_start_d;
            busy_q       <= busy_d;
            req_ready_q  <= req_ready_d;
            req_error_q  <= req_error_d;
        end
    end

    assign REQ_READY       = req_ready_q;
    assign REQ_ERROR       = req_error_q;
    assign REQ_POINT_OUT_X = out_x_q;
    assign REQ_POINT_OUT_Y = out_y_q;
    assign GRANT_ID        = grant_id_q;
    assign BUSY            = busy_q;
    assign GEN_START       = gen_start_q;
    assign GEN_POINT_IN_X  = gen_x_q;
    assign GEN_POINT_IN_Y  = gen_y_q;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_dsa_point_generator_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_dsa_point_generator_arbiter
// Purpose  : Self-checking bench for the point-generator arbiter. Drives
//            directed scenarios and random client traffic; a transaction
//            level model predicts grants, strobes and results.
// Revision : 1.0  initial release
// ============================================================================
module tb_peripheral_dsa_point_generator_arbiter;

    localparam int DW = 64;
    localparam int NR = 4;
    localparam int TO = 16;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NR-1:0]     v;
    logic [DW-1:0]     opx [NR];
    logic [DW-1:0]     opy [NR];
    logic [NR*DW-1:0]  in_x, in_y;
    logic [NR-1:0]     req_ready, req_error;
    logic [DW-1:0]     out_x, out_y, gen_in_x, gen_in_y;
    logic [DW-1:0]     gen_ox, gen_oy;
    logic [1:0]        grant_id;
    logic              busy, gen_start, gen_ready;

    assign in_x = {opx[3], opx[2], opx[1], opx[0]};
    assign in_y = {opy[3], opy[2], opy[1], opy[0]};

    peripheral_dsa_point_generator_arbiter #(
        .DATA_SIZE(DW), .REQUESTERS(NR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(v), .REQ_POINT_IN_X(in_x), .REQ_POINT_IN_Y(in_y),
        .REQ_READY(req_ready), .REQ_ERROR(req_error),
        .REQ_POINT_OUT_X(out_x), .REQ_POINT_OUT_Y(out_y),
        .GRANT_ID(grant_id), .BUSY(busy),
        .GEN_START(gen_start), .GEN_POINT_IN_X(gen_in_x), .GEN_POINT_IN_Y(gen_in_y),
        .GEN_READY(gen_ready), .GEN_POINT_OUT_X(gen_ox), .GEN_POINT_OUT_Y(gen_oy)
    );

    always #5 CLK = ~CLK;

    // bookkeeping
    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;
    // transaction model
    int            model_last;
    bit            inflight;
    int            win;
    logic [DW-1:0] ex, ey;
    int            exp_done;
    bit            exp_err;
    int            idle_from;
    int            grant_log [$];
    bit            keep [NR];
    int            n_err_strobes;
    logic [NR-1:0] last_strobe;
    logic [DW-1:0] last_ox, last_oy;
    // generator model
    bit            start_seen;
    int            gen_cnt;
    bit            gen_hang;
    int            fixed_lat;
    int            cur_lat;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Round-robin rule: first requester after the previous winner, wrapping.
    function automatic int rr(logic [NR-1:0] req, int last);
        for (int k = 1; k <= NR; k++)
            if (req[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    task automatic check_all_zero(string tag);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_error"}, req_error, 0);
        check({tag, "_outx"},  out_x, 0);
        check({tag, "_outy"},  out_y, 0);
        check({tag, "_gid"},   grant_id, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_start"}, gen_start, 0);
        check({tag, "_ginx"},  gen_in_x, 0);
        check({tag, "_giny"},  gen_in_y, 0);
    endtask

    // Called at a sample point (#1 after an edge); returns at a sample point
    // with RST released so the next edge may grant.
    task automatic do_reset(string tag);
        RST = 1'b0;
        v   = '0;
        for (int i = 0; i < NR; i++) keep[i] = 1'b0;
        inflight = 1'b0; model_last = NR - 1;
        gen_ready = 1'b1; gen_cnt = 0; gen_hang = 1'b0; start_seen = 1'b0;
        #1;
        check_all_zero({tag, "_async"});
        @(posedge CLK); #1;
        check_all_zero({tag, "_clocked"});
        RST = 1'b1;
        idle_from = t + 1;
    endtask

    task automatic step();
        logic [NR-1:0] sv;
        logic [DW-1:0] sx [NR];
        logic [DW-1:0] sy [NR];
        logic          sr, exp_start;
        logic [NR-1:0] exp_rdy, exp_er;
        int            w;
        sv = v; sr = gen_ready;
        for (int i = 0; i < NR; i++) begin sx[i] = opx[i]; sy[i] = opy[i]; end
        @(posedge CLK); #1; t++;

        // generator: drops READY after START, raises it cur_lat cycles later
        if (start_seen) begin
            gen_ready = 1'b0;
            gen_cnt   = cur_lat;
            gen_ox    = gen_in_x + 64'd1;
            gen_oy    = gen_in_y + 64'd1;
        end else if (gen_cnt > 0) begin
            gen_cnt--;
            if (gen_cnt == 0 && !gen_hang) gen_ready = 1'b1;
        end

        exp_start = !inflight && (t >= idle_from) && (sv != 0) && sr;
        check("gen_start", gen_start, exp_start);
        if (exp_start) begin
            w = rr(sv, model_last);
            check("grant_id", grant_id, w);
            check("gen_in_x", gen_in_x, sx[w]);
            check("gen_in_y", gen_in_y, sy[w]);
            inflight = 1'b1; win = w; ex = sx[w]; ey = sy[w];
            exp_err  = gen_hang;
            cur_lat  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 15));
            exp_done = gen_hang ? t + TO + 1 : t + cur_lat + 2;
            grant_log.push_back(w);
            // operands are don't-care after the grant edge
            opx[w] = 64'hFF; opy[w] = 64'hFF;
        end else if (inflight) begin
            check("gen_in_x_held", gen_in_x, ex);
            check("gen_in_y_held", gen_in_y, ey);
        end

        exp_rdy = (inflight && t == exp_done && !exp_err) ? (NR'(1) << win) : '0;
        exp_er  = (inflight && t == exp_done &&  exp_err) ? (NR'(1) << win) : '0;
        check("req_ready", req_ready, exp_rdy);
        check("req_error", req_error, exp_er);
        check("busy", busy, inflight);
        if (req_error != 0) n_err_strobes++;

        if (inflight && t == exp_done) begin
            check("out_x", out_x, exp_err ? 64'd0 : ex + 64'd1);
            check("out_y", out_y, exp_err ? 64'd0 : ey + 64'd1);
            last_strobe = req_ready; last_ox = out_x; last_oy = out_y;
            inflight   = 1'b0;
            idle_from  = t + 2;
            model_last = win;
            if (!keep[win]) v[win] = 1'b0;
        end
        start_seen = gen_start;
    endtask

    task automatic wait_quiet(string tag, int bound);
        int n = 0;
        while ((inflight || v != 0) && n < bound) begin step(); n++; end
        check({tag, "_drain_bound"}, (inflight || v != 0), 0);
    endtask

    task automatic wait_grants(string tag, int target, int bound);
        int n = 0;
        while (grant_log.size() < target && n < bound) begin step(); n++; end
        check({tag, "_grant_bound"}, grant_log.size() >= target, 1);
    endtask

    task automatic raise(int i, logic [DW-1:0] x, logic [DW-1:0] y);
        opx[i] = x; opy[i] = y; v[i] = 1'b1;
    endtask

    initial begin
        int base;
        v = '0; gen_ox = '0; gen_oy = '0; gen_ready = 1'b1; fixed_lat = 0;
        n_err_strobes = 0;
        for (int i = 0; i < NR; i++) begin opx[i] = '0; opy[i] = '0; end
        #1;
        do_reset("reset");

        // single request from client 2, generator latency 10
        base = grant_log.size();
        fixed_lat = 10;
        raise(2, 64'h11, 64'h22);
        wait_quiet("t1", 100);
        check("t1_winner", (grant_log.size() > base) ? grant_log[base] : -1, 2);
        check("t1_strobe", last_strobe, 4'b0100);
        check("t1_out_x", last_ox, 64'h12);
        check("t1_out_y", last_oy, 64'h23);
        step();
        check("t1_busy_after", busy, 0);

        // all clients requesting continuously from reset
        do_reset("t2rst");
        fixed_lat = 0;
        base = grant_log.size();
        for (int i = 0; i < NR; i++) begin
            keep[i] = 1'b1;
            raise(i, {$urandom, $urandom}, {$urandom, $urandom});
        end
        wait_grants("t2", base + 5, 200);
        for (int i = 0; i < 5; i++)
            check("t2_order", (grant_log.size() > base + i) ? grant_log[base + i] : -1, i % NR);
        for (int i = 0; i < NR; i++) keep[i] = 1'b0;
        wait_quiet("t2", 400);

        // client 3 arrives while client 1 is served; client 1 keeps VALID high
        base = grant_log.size();
        fixed_lat = 10;
        keep[1] = 1'b1;
        raise(1, 64'hA1, 64'hB1);
        wait_grants("t3a", base + 1, 20);
        for (int i = 0; i < 3; i++) step();
        raise(3, 64'hC3, 64'hD3);
        wait_grants("t3b", base + 3, 100);
        keep[1] = 1'b0;
        check("t3_first",  (grant_log.size() > base)     ? grant_log[base]     : -1, 1);
        check("t3_second", (grant_log.size() > base + 1) ? grant_log[base + 1] : -1, 3);
        check("t3_third",  (grant_log.size() > base + 2) ? grant_log[base + 2] : -1, 1);
        wait_quiet("t3", 100);

        // generator never raises READY: watchdog, then blocked until recovery
        gen_hang = 1'b1;
        n_err_strobes = 0;
        raise(0, 64'h55, 64'h66);
        wait_quiet("t4", 60);
        check("t4_err_count", n_err_strobes, 1);
        check("t4_last_ready", last_strobe, 0);
        base = grant_log.size();
        raise(1, 64'h77, 64'h88);
        for (int i = 0; i < 10; i++) step();
        check("t4_no_grant", grant_log.size(), base);
        check("t4_idle_busy", busy, 0);
        gen_hang = 1'b0; gen_cnt = 0; gen_ready = 1'b1;
        fixed_lat = 3;
        wait_quiet("t4r", 60);
        check("t4_recovered", (grant_log.size() > base) ? grant_log[base] : -1, 1);
        check("t4_recovered_out", last_ox, 64'h78);

        // asynchronous reset in the middle of a wait
        fixed_lat = 12;
        raise(2, 64'h123, 64'h456);
        wait_grants("t5", grant_log.size() + 1, 20);
        for (int i = 0; i < 4; i++) step();
        do_reset("t5rst");
        base = grant_log.size();
        fixed_lat = 0;
        raise(2, {$urandom, $urandom}, {$urandom, $urandom});
        raise(0, {$urandom, $urandom}, {$urandom, $urandom});
        wait_quiet("t5", 100);
        check("t5_first",  (grant_log.size() > base)     ? grant_log[base]     : -1, 0);
        check("t5_second", (grant_log.size() > base + 1) ? grant_log[base + 1] : -1, 2);

        // random traffic
        fixed_lat = 0;
        for (int c = 0; c < 500; c++) begin
            step();
            for (int i = 0; i < NR; i++)
                if (!v[i] && $urandom_range(0, 7) == 0)
                    raise(i, {$urandom, $urandom}, {$urandom, $urandom});
        end
        wait_quiet("rand", 400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed %0d checks", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
